rom_pixel_streamer: RTL and testbench

//  Sequences reads of the 8-bit image ROM (image_rom2: 15-bit address, registered q) and

---
 rtl/rom_pixel_streamer.sv | 181 ++++++++++++++++++
 tb/tb_rom_pixel_streamer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_pixel_streamer.sv
// rom_pixel_streamer: reads the image ROM in ascending address order and presents the
// frame as a valid/ready pixel stream. Each issued address is tracked through a
// ROM_LAT-deep pipe, and returned bytes go into a small FIFO. An issue credit check
// keeps the FIFO from ever overflowing under downstream back-pressure.
// When the FIFO is empty, a returning byte bypasses it so it is presented in the same
// cycle it arrives.
// Optional feature macro: STREAM_CHECKSUM_EN adds csum/csum_vld (frame pixel sum).
//
// state  | meaning
// IDLE   | waiting for start, rom_addr parked at 0
// RUN    | issuing addresses under FIFO credit
// DRAIN  | all addresses issued, emptying pipe and FIFO
// DONE   | last pixel accepted, one-cycle done pulse
`timescale 1ns/1ps

module rom_pixel_streamer #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 8,
   parameter int NUM_PIX    = 32768,
   parameter int ROM_LAT    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_q,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_last,
   output logic              busy,
   output logic              done
`ifdef STREAM_CHECKSUM_EN
   ,
   output logic [31:0]       csum,
   output logic              csum_vld
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W = $clog2(FIFO_DEPTH + ROM_LAT + 2) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic                run_en;

   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   last_q;
   logic                is_last_addr;
   logic                issue;

   logic [ROM_LAT-1:0]  vld_sr_q;
   logic [ROM_LAT-1:0]  lst_sr_q;
   logic                push;
   logic                push_last;

   logic [DATA_W:0]     mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                fifo_empty;
   logic                pop;
   logic                wr_en, rd_en;
   logic [OCC_W-1:0]    occ;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (issue && is_last_addr) state_d = S_DRAIN;
         S_DRAIN: if (pop && pix_last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy   = 1'b0;
      done   = 1'b0;
      run_en = 1'b0;
      case (state_q)
         S_RUN:   begin busy = 1'b1; run_en = 1'b1; end
         S_DRAIN: busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign is_last_addr = (addr_q == LAST_ADDR);
   assign push         = vld_sr_q[ROM_LAT-1];
   assign push_last    = lst_sr_q[ROM_LAT-1];
   assign fifo_empty   = (count_q == '0);

   // A returning byte bypasses an empty FIFO so the first pixel is not delayed
   assign pix_valid = !fifo_empty || push;
   assign pix_data  = fifo_empty ? rom_q : mem_q[rd_ptr_q][DATA_W-1:0];
   assign pix_last  = pix_valid && (fifo_empty ? push_last : mem_q[rd_ptr_q][DATA_W]);
   assign pop       = pix_valid && pix_ready;
   assign wr_en     = push && !(fifo_empty && pop);
   assign rd_en     = pop && !fifo_empty;
   assign count_d   = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);

   // Issue credit: buffered plus in-flight bytes, less this cycle's pop, must leave room
   always_comb begin
      occ = OCC_W'(count_q);
      for (int i = 0; i < ROM_LAT; i++) occ = occ + OCC_W'(vld_sr_q[i]);
      issue = run_en && (occ < (OCC_W'(FIFO_DEPTH) + OCC_W'(pop)));
   end

   assign rom_addr = (state_q == S_IDLE) ? '0 : (issue ? addr_q : last_q);

   // Address counter, in-flight pipe and FIFO pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q   <= '0;
         last_q   <= '0;
         vld_sr_q <= '0;
         lst_sr_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (state_q == S_IDLE) begin
            addr_q <= '0;
            last_q <= '0;
         end else if (issue) begin
            last_q <= addr_q;
            // hold at the last address so a full 2**ADDR_W frame never wraps to 0
            if (!is_last_addr) addr_q <= addr_q + 1'b1;
         end
         vld_sr_q[0] <= issue;
         lst_sr_q[0] <= issue && is_last_addr;
         for (int i = 1; i < ROM_LAT; i++) begin
            vld_sr_q[i] <= vld_sr_q[i-1];
            lst_sr_q[i] <= lst_sr_q[i-1];
         end
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // FIFO storage; contents need no reset since count_q gates every read
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= {push_last, rom_q};
   end

`ifdef STREAM_CHECKSUM_EN
   logic [31:0] csum_q;
   logic        csum_vld_q;

   // Running sum of accepted pixels, flagged valid from the DONE cycle until next start
   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q     <= '0;
         csum_vld_q <= 1'b0;
      end else if (state_q == S_IDLE && start) begin
         csum_q     <= '0;
         csum_vld_q <= 1'b0;
      end else begin
         if (pop) csum_q <= csum_q + 32'(pix_data);
         if (state_q == S_DRAIN && state_d == S_DONE) csum_vld_q <= 1'b1;
      end
   end

   assign csum     = csum_q;
   assign csum_vld = csum_vld_q;
`endif

endmodule

// File: tb/tb_rom_pixel_streamer.sv
// Bench for rom_pixel_streamer: three instances (full 32768-pixel frame, 256-pixel frame,
// single-pixel frame) share clock, reset and pix_ready; start is routed to the selected one.
`timescale 1ns/1ps

module tb_rom_pixel_streamer;

   localparam int AW = 15;
   localparam int DEPTH = 4;

   logic clk, rst, start, pix_ready;
   int   sel;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [AW-1:0] addr_b, addr_s, addr_o;
   logic [7:0]    q_b, q_s, q_o, q1_b, q1_s, q1_o;
   logic [7:0]    d_b, d_s, d_o;
   logic          v_b, v_s, v_o, l_b, l_s, l_o;
   logic          bz_b, bz_s, bz_o, dn_b, dn_s, dn_o;
   logic          st_b, st_s, st_o;
`ifdef STREAM_CHECKSUM_EN
   logic [31:0]   cs_b, cs_s, cs_o, m_csum;
   logic          cv_b, cv_s, cv_o, m_cvld;
`endif

   logic [AW-1:0] m_addr;
   logic [7:0]    m_data;
   logic          m_valid, m_last, m_busy, m_done;

   assign st_b = start && (sel == 0);
   assign st_s = start && (sel == 1);
   assign st_o = start && (sel == 2);

   rom_pixel_streamer #(.NUM_PIX(32768)) u_big (
      .clk(clk), .rst(rst), .start(st_b), .rom_addr(addr_b), .rom_q(q_b),
      .pix_data(d_b), .pix_valid(v_b), .pix_ready(pix_ready), .pix_last(l_b),
      .busy(bz_b), .done(dn_b)
`ifdef STREAM_CHECKSUM_EN
      , .csum(cs_b), .csum_vld(cv_b)
`endif
   );

   rom_pixel_streamer #(.NUM_PIX(256)) u_small (
      .clk(clk), .rst(rst), .start(st_s), .rom_addr(addr_s), .rom_q(q_s),
      .pix_data(d_s), .pix_valid(v_s), .pix_ready(pix_ready), .pix_last(l_s),
      .busy(bz_s), .done(dn_s)
`ifdef STREAM_CHECKSUM_EN
      , .csum(cs_s), .csum_vld(cv_s)
`endif
   );

   rom_pixel_streamer #(.NUM_PIX(1)) u_one (
      .clk(clk), .rst(rst), .start(st_o), .rom_addr(addr_o), .rom_q(q_o),
      .pix_data(d_o), .pix_valid(v_o), .pix_ready(pix_ready), .pix_last(l_o),
      .busy(bz_o), .done(dn_o)
`ifdef STREAM_CHECKSUM_EN
      , .csum(cs_o), .csum_vld(cv_o)
`endif
   );

   // ROM models: q = addr[7:0], two registered stages
   always_ff @(posedge clk) begin
      q1_b <= addr_b[7:0]; q_b <= q1_b;
      q1_s <= addr_s[7:0]; q_s <= q1_s;
      q1_o <= addr_o[7:0]; q_o <= q1_o;
   end

   always_comb begin
      m_addr = addr_b; m_data = d_b; m_valid = v_b; m_last = l_b; m_busy = bz_b; m_done = dn_b;
`ifdef STREAM_CHECKSUM_EN
      m_csum = cs_b; m_cvld = cv_b;
`endif
      if (sel == 1) begin
         m_addr = addr_s; m_data = d_s; m_valid = v_s; m_last = l_s; m_busy = bz_s; m_done = dn_s;
`ifdef STREAM_CHECKSUM_EN
         m_csum = cs_s; m_cvld = cv_s;
`endif
      end else if (sel == 2) begin
         m_addr = addr_o; m_data = d_o; m_valid = v_o; m_last = l_o; m_busy = bz_o; m_done = dn_o;
`ifdef STREAM_CHECKSUM_EN
         m_csum = cs_o; m_cvld = cv_o;
`endif
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   // One frame on instance s, checking order, last flag, stalls, latency and done timing
   task automatic run_frame(input int s, input int npix, input int stall_pct, input int hold,
                            input bit extra_starts, input logic [31:0] exp_csum);
      int cyc, idx, last_cyc, budget;
      bit prev_stall, done_seen, first_seen;
      logic [7:0] pd;
      logic pl;
      sel = s;
      cyc = 0; idx = 0; last_cyc = -10; budget = npix * 4 + 200;
      prev_stall = 0; done_seen = 0; first_seen = 0; pd = '0; pl = 0;
      start = 1'b1;
      while (!done_seen && cyc < budget) begin
         if (cyc > 0) start = extra_starts && (cyc == 5 || cyc == 60);
         if (cyc < hold)          pix_ready = 1'b0;
         else if (stall_pct > 0)  pix_ready = ($urandom_range(0, 99) >= stall_pct);
         else                     pix_ready = 1'b1;
         @(negedge clk);
         if (prev_stall) begin
            check("stall_valid_held", 32'(m_valid), 32'd1);
            check("stall_data_held", 32'(m_data), 32'(pd));
            check("stall_last_held", 32'(m_last), 32'(pl));
         end
         if (hold > 0 && cyc == hold - 1) begin
            check("hold_issued_addr", 32'(m_addr), 32'(DEPTH - 1));
            check("hold_head_data", 32'(m_data), 32'd0);
         end
         if (m_valid && !first_seen) begin
            first_seen = 1;
            check("first_valid_cycle", cyc, 3);
         end
         if (m_valid && pix_ready) begin
            check("beat_data", 32'(m_data), 32'(idx[7:0]));
            check("beat_last", 32'(m_last), 32'(idx == npix - 1));
            if (idx == npix - 1) last_cyc = cyc;
            idx++;
         end
         prev_stall = m_valid && !pix_ready;
         pd = m_data;
         pl = m_last;
         if (m_done) begin
            done_seen = 1;
            check("done_cycle", cyc, last_cyc + 1);
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      pix_ready = 1'b1;
      check("frame_beats", idx, npix);
      check("done_seen", 32'(done_seen), 32'd1);
      @(negedge clk);
      check("idle_busy", 32'(m_busy), 32'd0);
      check("idle_rom_addr", 32'(m_addr), 32'd0);
`ifdef STREAM_CHECKSUM_EN
      check("csum", m_csum, exp_csum);
      check("csum_vld", 32'(m_cvld), 32'd1);
`else
      if (exp_csum == 32'hFFFF_FFFF) $display("unused checksum argument");
`endif
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic       start;
      logic       ready;
      logic       valid;
      logic [7:0] data;
      logic       last;
      logic       busy;
      logic       done;
      logic [AW-1:0] addr;
   } vec_t;

   vec_t vecs[10];

   initial begin
      //           start ready valid data last busy done addr
      vecs[0] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 15'd0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 15'd0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 15'd1};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 15'd2};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 15'd3};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 15'd3};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 15'd4};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 15'd5};
      vecs[8] = '{1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 15'd6};
      vecs[9] = '{1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 15'd7};

      rst = 1'b1; start = 1'b1; pix_ready = 1'b1; sel = 0;
      repeat (3) @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      // start together with rst: reset must win, every instance idle
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         check("rst_valid", 32'(m_valid), 32'd0);
         check("rst_busy", 32'(m_busy), 32'd0);
         check("rst_done", 32'(m_done), 32'd0);
         check("rst_last", 32'(m_last), 32'd0);
         check("rst_rom_addr", 32'(m_addr), 32'd0);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;

      // cycle-exact start-up with an early stall on the 256-pixel instance
      sel = 1;
      for (int i = 0; i < 10; i++) begin
         start = vecs[i].start;
         pix_ready = vecs[i].ready;
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vecs[i].valid));
         if (vecs[i].valid) check($sformatf("vec%0d_data", i), 32'(m_data), 32'(vecs[i].data));
         check($sformatf("vec%0d_last", i), 32'(m_last), 32'(vecs[i].last));
         check($sformatf("vec%0d_busy", i), 32'(m_busy), 32'(vecs[i].busy));
         check($sformatf("vec%0d_done", i), 32'(m_done), 32'(vecs[i].done));
         check($sformatf("vec%0d_rom_addr", i), 32'(m_addr), 32'(vecs[i].addr));
         @(posedge clk); #1;
      end
      start = 1'b0;

      // abort mid-frame with rst
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("abort_small_valid", 32'(m_valid), 32'd0);
      check("abort_small_busy", 32'(m_busy), 32'd0);
      check("abort_small_done", 32'(m_done), 32'd0);
      @(posedge clk); #1;

      run_frame(1, 256, 30, 0, 1'b0, 32'd32640);   // random back-pressure
      run_frame(1, 256, 0, 100, 1'b0, 32'd32640);  // long stall then resume
      run_frame(1, 256, 0, 0, 1'b1, 32'd32640);    // start pulses while busy
      run_frame(2, 1, 0, 0, 1'b0, 32'd0);          // single-pixel frame

      // full frame aborted by rst after 1000 beats
      sel = 0;
      begin
         int beats, cyc;
         beats = 0; cyc = 0;
         start = 1'b1; pix_ready = 1'b1;
         while (beats < 1000 && cyc < 3000) begin
            if (cyc > 0) start = 1'b0;
            @(negedge clk);
            if (m_valid && pix_ready) begin
               check("pre_rst_data", 32'(m_data), 32'(beats[7:0]));
               beats++;
            end
            @(posedge clk); #1;
            cyc++;
         end
         start = 1'b0;
         check("pre_rst_beats", beats, 1000);
         rst = 1'b1;
         @(negedge clk);
         @(posedge clk); #1 rst = 1'b0;
         @(negedge clk);
         check("abort_big_valid", 32'(m_valid), 32'd0);
         check("abort_big_busy", 32'(m_busy), 32'd0);
         check("abort_big_done", 32'(m_done), 32'd0);
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(m_done), 32'd0);
         end
         @(posedge clk); #1;
      end

      run_frame(0, 32768, 0, 0, 1'b0, 32'd4177920);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
